ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, directly downstream of ID. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations issued by ID with the register operands ID has already read, and owns the architectural HI/LO registers. MULT, MULTU, DIV and DIVU each take 32 cycles. `busy` is used by the hazard logic to stall ID while an operation is in progress.

## Interface
- No parameters; data width is fixed at 32.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — ID issues an op this cycle.
- `op`  in  3  — 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op (ignored).
- `rs_data`  in  32  — multiplicand / dividend / MTHI-MTLO source.
- `rt_data`  in  32  — multiplier / divisor.
- `flush`  in  1  — abort the in-flight op (branch/exception squash).
- `busy`  out  1  — registered; high while a multiply/divide is iterating.
- `done`  out  1  — registered one-cycle pulse when HI/LO have just been written.
- `hi`  out  32  — architectural HI register (read by MFHI).
- `lo`  out  32  — architectural LO register (read by MFLO).

## Operation
- FSM has two states, IDLE and RUN. Reset drives IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, iteration counter=0, and clears all internal operand registers.
- An op is accepted on a rising edge when `start`=1, state=IDLE, `flush`=0 and `op` is not 11x.
- A `start` while in RUN is ignored. ID must hold the instruction while `busy`=1.
- MTHI/MTLO: on the accept edge, `hi` or `lo` is loaded with `rs_data`, `done` pulses the next cycle, and the state stays IDLE.
- MULT/DIV, accept edge:
  - Latch the absolute values of `rs_data` and `rt_data`.
  - Latch `neg_q` = sign(rs) XOR sign(rt) and `neg_r` = sign(rs).
  - Enter RUN with counter=0.
- MULTU/DIVU: operands are latched unmodified; the sign flags are cleared.
- Multiply: radix-2 shift-add. Each RUN cycle conditionally adds the multiplicand into a 64-bit accumulator and shifts, consuming one multiplier bit, LSB first.
- Divide: radix-2 restoring. A 33-bit partial remainder is compared with the divisor each cycle, producing one quotient bit, MSB first.
- Counter is 5 bits and increments every RUN cycle. The cycle in which counter=31 is the last iteration. On that edge:
  - Apply sign fix-up: two's-complement negation of the 64-bit product, of the quotient when `neg_q`, and of the remainder when `neg_r`.
  - MULT/MULTU write `hi`=product[63:32], `lo`=product[31:0].
  - DIV/DIVU write `lo`=quotient, `hi`=remainder.
  - Return to IDLE and set `done`=1 for one cycle.
- Divide by zero (DIV/DIVU, `rt_data`=0): still runs 32 cycles; result `lo`=32'hFFFFFFFF, `hi`=`rs_data` (sign fix-up not applied to the quotient).
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (the natural wrap of the absolute-value scheme).
- `flush`=1 in RUN: return to IDLE on that edge. `hi`/`lo` are unchanged and no `done` pulse is produced.
- `flush` and `start` asserted together in IDLE: flush wins and the op is not accepted.
- Async reset during RUN: immediate return to reset values; the partial result is discarded.

## Timing
- Accept edge E0. `busy`=1 in the cycles after E0 through E31, i.e. exactly 32 cycles of `busy`.
- Result edge E32: `hi`/`lo` are updated, `busy` falls, and `done`=1 during the cycle after E32.
- A new `start` is accepted at E33 (the `done` cycle); back-to-back issue is therefore allowed.
- MTHI/MTLO: `hi`/`lo` are visible the cycle after the accept edge, with `done`=1 in that same cycle. `busy` never rises.
- `hi`/`lo` change only on MTHI/MTLO accept edges or on result edges.

## Test plan
- Reset: hold `rst`=0 with random inputs, then release → `hi`=0, `lo`=0, `busy`=0, `done`=0. Asserting `rst` mid-RUN clears all state immediately.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → exactly 32 `busy` cycles, then `hi`=0xFFFFFFFE, `lo`=0x00000001, one-cycle `done`.
- MULT 0xFFFFFFFD(−3)×7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100/0 → `lo`=0xFFFFFFFF, `hi`=100. DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → each value visible one cycle later, `busy` stays 0. A `start` during RUN is ignored and the RUN result is unaffected.
- MULT started, `flush` at iteration 10 → `busy` drops next cycle, `hi`/`lo` hold their previous values, no `done`. `start`+`flush` together in IDLE → nothing accepted.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-cycle multiply/divide unit in the EX stage.
// Owns the architectural HI/LO registers. Multiply is radix-2 shift-add
// (LSB first), divide is radix-2 restoring (MSB first). Signed operations
// run on magnitudes and negate the results on the final iteration.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic        is_div_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        dz_reg;
  logic [31:0] b_reg;      // multiplicand or divisor magnitude
  logic [63:0] acc_reg;    // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [63:0] acc_next;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  logic        accept, accept_md, signed_op, last_iter;
  logic [31:0] rs_abs, rt_abs;
  logic [32:0] mul_sum;
  logic [32:0] div_part;
  logic [31:0] div_sub;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Accept only in IDLE, never alongside a flush, and never for the 11x no-ops.
  assign accept    = start && (state_reg == IDLE) && !flush && (op[2:1] != 2'b11);
  assign accept_md = accept && !op[2];
  assign signed_op = !op[0];
  assign last_iter = (state_reg == RUN) && !flush && (cnt_reg == 5'd31);

  assign rs_abs = (signed_op && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
  assign rt_abs = (signed_op && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

  assign mul_sum  = {1'b0, acc_reg[63:32]} + {1'b0, b_reg};
  assign div_part = {acc_reg[63:32], acc_reg[31]};
  assign div_ge   = div_part >= {1'b0, b_reg};
  // After a successful trial subtract the remainder is below the divisor, so 32 bits suffice.
  assign div_sub  = div_part[31:0] - b_reg;

  // One iteration step of the shared accumulator.
  always_comb begin
    acc_next = acc_reg;
    if (is_div_reg) begin
      if (div_ge) acc_next = {div_sub, acc_reg[30:0], 1'b1};
      else        acc_next = {div_part[31:0], acc_reg[30:0], 1'b0};
    end else begin
      if (acc_reg[0]) acc_next = {mul_sum, acc_reg[31:1]};
      else            acc_next = {1'b0, acc_reg[63:32], acc_reg[31:1]};
    end
  end

  // Sign fix-up; a divide by zero keeps the all-ones quotient untouched.
  assign prod_fix = neg_q_reg ? (~acc_next + 64'd1) : acc_next;
  assign quo_fix  = (neg_q_reg && !dz_reg) ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
  assign rem_fix  = neg_r_reg ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic: flush or the final iteration returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept_md) state_next = RUN;
      RUN:  if (flush || cnt_reg == 5'd31) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg    <= 5'd0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      b_reg      <= 32'd0;
      acc_reg    <= 64'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept_md) begin
        cnt_reg    <= 5'd0;
        is_div_reg <= op[1];
        neg_q_reg  <= signed_op && (rs_data[31] ^ rt_data[31]);
        neg_r_reg  <= signed_op && rs_data[31];
        dz_reg     <= (rt_data == 32'd0);
        b_reg      <= rt_abs;
        acc_reg    <= {32'd0, rs_abs};
      end
      if (accept && op == OP_MTHI) begin
        hi_reg   <= rs_data;
        done_reg <= 1'b1;
      end
      if (accept && op == OP_MTLO) begin
        lo_reg   <= rs_data;
        done_reg <= 1'b1;
      end
      if (state_reg == RUN && !flush) begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg + 5'd1;
      end
      if (last_iter) begin
        done_reg <= 1'b1;
        if (is_div_reg) begin
          lo_reg <= quo_fix;
          hi_reg <= rem_fix;
        end else begin
          lo_reg <= prod_fix[31:0];
          hi_reg <= prod_fix[63:32];
        end
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against a plain
// arithmetic reference model of MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_bad;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  ex_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural result of one op, updates exp_hi/exp_lo.
  task automatic model(input logic [2:0] m_op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (m_op)
      3'b000: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'b001: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'b010: begin
        if (b == 32'd0) begin exp_lo = 32'hFFFFFFFF; exp_hi = a; end
        else begin
          sq = sa / sb; sr = sa % sb;
          exp_lo = 32'(sq); exp_hi = 32'(sr);
        end
      end
      3'b011: begin
        if (b == 32'd0) begin exp_lo = 32'hFFFFFFFF; exp_hi = a; end
        else begin exp_lo = a / b; exp_hi = a % b; end
      end
      3'b100: exp_hi = a;
      3'b101: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue a mul/div at the current negedge and follow it to its done pulse.
  // Ends at the negedge where done is seen (so the next call issues back-to-back).
  task automatic do_op(input string name, input logic [2:0] d_op, input logic [31:0] a, input logic [31:0] b);
    int busy_cnt;
    int n;
    start = 1'b1; op = d_op; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; op = 3'b110; rs_data = $urandom; rt_data = $urandom;
    model(d_op, a, b);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", name, busy, done);
    end
    busy_cnt = 0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_bad++;
      $display("FAIL %s timeout: no done after %0d cycles, required done", name, n);
    end else if (busy_cnt != 32 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_bad++;
      $display("FAIL %s result: op=%b a=%h b=%h busy_cycles=%0d busy=%b hi=%h lo=%h, required 32 0 hi=%h lo=%h",
               name, d_op, a, b, busy_cnt, busy, hi, lo, exp_hi, exp_lo);
    end else begin
      $display("op %s %b a=%h b=%h -> hi=%h lo=%h", name, d_op, a, b, hi, lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); op = 3'($urandom); rs_data = $urandom; rt_data = $urandom; flush = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0; op = 3'b110;
    rst = 1'b1;
    @(negedge clk);
    exp_hi = 32'd0; exp_lo = 32'd0;
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, required all zero", hi, lo, busy, done);
    end else $display("reset: outputs zero");
  endtask

  task automatic test_directed();
    do_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n_cmp++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      n_bad++;
      $display("FAIL multu_max const: hi=%h lo=%h, required fffffffe 00000001", hi, lo);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_width: done=%b, required 0", done);
    end
    do_op("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7);
    n_cmp++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      n_bad++;
      $display("FAIL mult_neg const: hi=%h lo=%h, required ffffffff ffffffeb", hi, lo);
    end
    @(negedge clk);
    do_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2);
    n_cmp++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_bad++;
      $display("FAIL div_neg const: hi=%h lo=%h, required ffffffff fffffffd", hi, lo);
    end
    @(negedge clk);
    do_op("divu_zero", 3'b011, 32'd100, 32'd0);
    n_cmp++;
    if (hi !== 32'd100 || lo !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL divu_zero const: hi=%h lo=%h, required 00000064 ffffffff", hi, lo);
    end
    @(negedge clk);
    do_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF);
    n_cmp++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      n_bad++;
      $display("FAIL div_ovf const: hi=%h lo=%h, required 00000000 80000000", hi, lo);
    end
    @(negedge clk);
    do_op("div_neg_zero", 3'b010, 32'hFFFFFF00, 32'd0);
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; op = 3'b100; rs_data = 32'h12345678;
    @(negedge clk);
    op = 3'b101; rs_data = 32'h9ABCDEF0;
    model(3'b100, 32'h12345678, 32'd0);
    n_cmp++;
    if (hi !== exp_hi || done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mthi: hi=%h done=%b busy=%b, required %h 1 0", hi, done, busy, exp_hi);
    end else $display("mthi %h", hi);
    @(negedge clk);
    start = 1'b0; op = 3'b110;
    model(3'b101, 32'h9ABCDEF0, 32'd0);
    n_cmp++;
    if (lo !== exp_lo || hi !== exp_hi || done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mtlo: hi=%h lo=%h done=%b busy=%b, required %h %h 1 0", hi, lo, done, busy, exp_hi, exp_lo);
    end else $display("mtlo %h", lo);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mt_idle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_start_in_run();
    logic [31:0] a, b;
    logic [31:0] h0;
    int n;
    a = $urandom; b = $urandom;
    h0 = exp_hi;
    start = 1'b1; op = 3'b001; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'b100; rs_data = ~h0;
    @(negedge clk);
    start = 1'b0; op = 3'b110;
    model(3'b001, a, b);
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 100 || hi !== exp_hi || lo !== exp_lo) begin
      n_bad++;
      $display("FAIL start_in_run: hi=%h lo=%h, required %h %h", hi, lo, exp_hi, exp_lo);
    end else $display("start_in_run multu %h*%h -> %h %h", a, b, hi, lo);
    @(negedge clk);
  endtask

  task automatic test_flush();
    int bad;
    start = 1'b1; op = 3'b000; rs_data = $urandom; rt_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      n_bad++;
      $display("FAIL flush_run: busy=%b done=%b hi=%h lo=%h, required 0 0 %h %h", busy, done, hi, lo, exp_hi, exp_lo);
    end else $display("flush during run: idle, hi/lo held");
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL flush_quiet: %0d disturbed cycles, required 0", bad);
    end
    // start together with flush in IDLE: nothing accepted
    start = 1'b1; flush = 1'b1; op = 3'b100; rs_data = ~exp_hi;
    @(negedge clk);
    op = 3'b000; rs_data = $urandom; rt_data = $urandom;
    n_cmp++;
    if (hi !== exp_hi || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_start_mt: hi=%h done=%b busy=%b, required %h 0 0", hi, done, busy, exp_hi);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_start_mul: busy=%b done=%b, required 0 0", busy, done);
    end else $display("start+flush in idle: ignored");
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; op = 3'b010; rs_data = $urandom; rt_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_run: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end else $display("async reset mid-run: cleared");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op("after_reset", 3'b011, 32'd1000, 32'd7);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_op("b2b_1", 3'b000, 32'h7FFFFFFF, 32'h80000000);
    do_op("b2b_2", 3'b011, 32'hDEADBEEF, 32'h00001234);
    do_op("b2b_3", 3'b010, 32'h80000000, 32'd3);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] r_op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'($urandom_range(0, 255));
        3: b = {1'b1, 31'($urandom_range(0, 7))};
        default: ;
      endcase
      do_op("rand", r_op, a, b);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    rst = 1'b0; start = 1'b0; op = 3'b110; rs_data = 32'd0; rt_data = 32'd0; flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_start_in_run();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
